// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings and default width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/half_subtractor.sv
// Gate-level half subtractor: d = x - y, borrow-out when x < y.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);

   assign d  = x ^ y;
   assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit per clock with a
// start/busy/done handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold last result
// ST_RUN  | one full-subtractor step per cycle, WIDTH steps in total
// ST_DONE | single cycle: done=1, diff/borrow just registered; accepts start
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] ra_q, rb_q, rd_q;
   logic [CW-1:0]    count_q;
   logic             bin_q;
   logic             busy_q, done_q, borrow_q;
   logic [WIDTH-1:0] diff_q;

   logic             d1, b1, d_bit, b2, bo;
   logic [WIDTH-1:0] rd_d;

   // Full subtractor: two half subtractors, borrows merged by an OR.
   half_subtractor u_hs_xy (
      .x  (ra_q[0]),
      .y  (rb_q[0]),
      .d  (d1),
      .bo (b1)
   );

   half_subtractor u_hs_bin (
      .x  (d1),
      .y  (bin_q),
      .d  (d_bit),
      .bo (b2)
   );

   assign bo   = b1 | b2;
   assign rd_d = {d_bit, rd_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ra_q     <= '0;
         rb_q     <= '0;
         rd_q     <= '0;
         count_q  <= '0;
         bin_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  ra_q    <= a;
                  rb_q    <= b;
                  bin_q   <= 1'b0;
                  count_q <= '0;
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               ra_q    <= ra_q >> 1;
               rb_q    <= rb_q >> 1;
               rd_q    <= rd_d;
               bin_q   <= bo;
               count_q <= count_q + 1'b1;
               // Final step: capture the completed result straight into the outputs.
               if (count_q == LAST) begin
                  state_q  <= ST_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  diff_q   <= rd_d;
                  borrow_q <= bo;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule
